// File: rtl/elastic_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_buffer_if
//  Description : Valid/ready handshake bundle plus occupancy status for the
//                elastic buffer. The slave modport is the buffer side and the
//                master modport is the surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface elastic_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic [c_CNT_W-1:0]    count_o;
    logic                  almost_full_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output count_o,
        output almost_full_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  count_o,
        input  almost_full_o
    );
endinterface
`default_nettype wire

// File: rtl/elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : elastic_buffer
//  Description : DEPTH-entry elastic buffer between two valid/ready stages.
//                in_ready, out_valid, out_data, count and almost_full are all
//                flop-driven, so the ready path is broken.
//                Optional feature macro: ELASTIC_BUFFER_CUT_THROUGH_EN
//                (zero-latency bypass when the buffer is empty).
//  Revision    : 1.0 - initial release
// ============================================================================
module elastic_buffer #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = 3
) (
    input  logic              clk,
    input  logic              rst,
    elastic_buffer_if.slave   bus
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_AFULL = c_CNT_W'(AFULL_THRESH);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(DEPTH - 1);

    // Storage (never reset) and control state
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_afull;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_store;
    logic                  w_take;
    logic                  w_out_valid;
    logic [DATA_WIDTH-1:0] w_out_data;
    logic [c_PTR_W-1:0]    w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]    w_rd_ptr_nxt;
    logic [c_CNT_W-1:0]    w_count_nxt;
    logic [DATA_WIDTH-1:0] w_head_nxt;

    // Handshakes, output muxing and the next control state
    always_comb begin
        w_push       = bus.in_valid_i & r_in_ready;
`ifdef ELASTIC_BUFFER_CUT_THROUGH_EN
        // With nothing stored, the incoming beat is presented directly.
        w_out_valid  = r_out_valid | ((r_count == '0) & bus.in_valid_i);
        w_out_data   = r_out_valid ? r_out_data
                     : (bus.in_valid_i ? bus.in_data_i : '0);
        w_bypass     = (r_count == '0) & w_push & bus.out_ready_i;
`else
        w_out_valid  = r_out_valid;
        w_out_data   = r_out_data;
        w_bypass     = 1'b0;
`endif
        w_pop        = w_out_valid & bus.out_ready_i;
        // A bypassed beat neither enters nor leaves storage.
        w_store      = w_push & ~w_bypass;
        w_take       = w_pop & ~w_bypass;

        w_wr_ptr_nxt = r_wr_ptr;
        if (w_store) begin
            w_wr_ptr_nxt = (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
        end
        w_rd_ptr_nxt = r_rd_ptr;
        if (w_take) begin
            w_rd_ptr_nxt = (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
        end

        w_count_nxt = r_count;
        case ({w_store, w_take})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase

        // The next head is the beat being written now only when it lands
        // exactly at the next read position (buffer empty after this cycle's
        // pop); otherwise it is already in storage.
        w_head_nxt = '0;
        if (w_count_nxt != '0) begin
            if (w_store && (r_wr_ptr == w_rd_ptr_nxt)) begin
                w_head_nxt = bus.in_data_i;
            end else begin
                w_head_nxt = r_mem[w_rd_ptr_nxt];
            end
        end
    end

    // Storage write on an accepted, non-bypassed beat
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= bus.in_data_i;
        end
    end

    // Control state and registered outputs; reset overrides any handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_afull     <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_in_ready  <= (w_count_nxt < c_DEPTH);
            r_out_valid <= (w_count_nxt != '0);
            r_out_data  <= w_head_nxt;
            r_afull     <= (w_count_nxt >= c_AFULL);
        end
    end

    assign bus.in_ready_o    = r_in_ready;
    assign bus.out_valid_o   = w_out_valid;
    assign bus.out_data_o    = w_out_data;
    assign bus.count_o       = r_count;
    assign bus.almost_full_o = r_afull;

endmodule
`default_nettype wire

// File: tb/tb_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elastic_buffer
//  Description : Self-checking bench for elastic_buffer using a queue-based
//                reference model of the FIFO contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_buffer;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFULL = 3;
`ifdef ELASTIC_BUFFER_CUT_THROUGH_EN
    localparam bit c_CUT = 1'b1;
`else
    localparam bit c_CUT = 1'b0;
`endif

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    elastic_buffer_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    elastic_buffer #(
        .DATA_WIDTH   (DW),
        .DEPTH        (DEPTH),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the beats currently held, oldest first
    logic [DW-1:0] q[$];
    bit            m_pushed;

    function automatic bit m_valid();
        return (q.size() != 0) || (c_CUT && bus.in_valid_i);
    endfunction

    function automatic logic [DW-1:0] m_data();
        if (q.size() != 0) return q[0];
        if (c_CUT && bus.in_valid_i) return bus.in_data_i;
        return '0;
    endfunction

    function automatic int  m_count();  return q.size();          endfunction
    function automatic bit  m_ready();  return q.size() < DEPTH;  endfunction
    function automatic bit  m_afull();  return q.size() >= AFULL; endfunction

    // Apply this cycle's handshakes to the model, then move to the next cycle
    task automatic next_cycle();
        bit push;
        bit pop;
        push = bus.in_valid_i && m_ready();
        pop  = m_valid() && bus.out_ready_i;
        m_pushed = push;
        if (!(c_CUT && q.size() == 0 && push && pop)) begin
            if (pop)  void'(q.pop_front());
            if (push) q.push_back(bus.in_data_i);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready_o); end
        checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid_o); end
        checks++; if (bus.out_data_o !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", bus.out_data_o); end
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.almost_full_o !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b want 0", bus.almost_full_o); end
        next_cycle();
    endtask

    task automatic test_fill();
        logic [DW-1:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = vals[i];
            @(negedge clk);
            checks++; if (bus.count_o !== 3'(i)) begin errors++; $display("FAIL fill_count: got %0d want %0d", bus.count_o, i); end
            checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready: got %b want 1", bus.in_ready_o); end
            checks++; if (bus.almost_full_o !== (i >= AFULL)) begin errors++; $display("FAIL fill_afull: got %b want %b", bus.almost_full_o, (i >= AFULL)); end
            next_cycle();
        end
        bus.in_data_i = 8'h55;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", bus.count_o); end
            checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", bus.in_ready_o); end
            checks++; if (bus.almost_full_o !== 1'b1) begin errors++; $display("FAIL full_afull: got %b want 1", bus.almost_full_o); end
            checks++; if (bus.out_data_o !== 8'h11) begin errors++; $display("FAIL full_head: got %h want 11", bus.out_data_o); end
            next_cycle();
        end
    endtask

    task automatic test_full_pop();
        logic [DW-1:0] drain [4];
        drain = '{8'h22, 8'h33, 8'h44, 8'h55};
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready_o !== 1'b0) begin errors++; $display("FAIL fullpop_ready: got %b want 0", bus.in_ready_o); end
        checks++; if (bus.out_data_o !== 8'h11) begin errors++; $display("FAIL fullpop_data: got %h want 11", bus.out_data_o); end
        next_cycle();
        bus.out_ready_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL fullpop_count: got %0d want 3", bus.count_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL fullpop_ready_rise: got %b want 1", bus.in_ready_o); end
        next_cycle();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd4) begin errors++; $display("FAIL fullpop_accept: got %0d want 4", bus.count_o); end
        next_cycle();
        bus.out_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== drain[k]) begin errors++; $display("FAIL drain_order: got %b/%h want 1/%h", bus.out_valid_o, bus.out_data_o, drain[k]); end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b0 || bus.count_o !== 3'd0) begin errors++; $display("FAIL drain_empty: got valid=%b count=%0d want 0/0", bus.out_valid_o, bus.count_o); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'(i);
            @(negedge clk);
            if (c_CUT) begin
                checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'(i)) begin errors++; $display("FAIL stream_data: got %b/%h want 1/%h", bus.out_valid_o, bus.out_data_o, 8'(i)); end
            end else if (i != 0) begin
                checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'(i - 1)) begin errors++; $display("FAIL stream_data: got %b/%h want 1/%h", bus.out_valid_o, bus.out_data_o, 8'(i - 1)); end
            end else begin
                checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b want 0", bus.out_valid_o); end
            end
            checks++; if (bus.count_o > 3'd1) begin errors++; $display("FAIL stream_count: got %0d want <=1", bus.count_o); end
            next_cycle();
        end
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid_o !== !c_CUT || (!c_CUT && bus.out_data_o !== 8'h09)) begin errors++; $display("FAIL stream_last: got %b/%h want %b/09", bus.out_valid_o, bus.out_data_o, !c_CUT); end
        next_cycle();
        @(negedge clk);
        next_cycle();
    endtask

    task automatic test_random();
        int  sent;
        int  cyc;
        bit  pending;
        sent = 0; cyc = 0; pending = 1'b0;
        while (sent < 1000 && cyc < 20000) begin
            if (!pending) begin
                bus.in_valid_i = $urandom_range(0, 1) == 1;
                bus.in_data_i  = DW'($urandom);
            end
            bus.out_ready_i = $urandom_range(0, 1) == 1;
            @(negedge clk);
            checks++; if (bus.count_o !== 3'(m_count())) begin errors++; $display("FAIL rand_count: got %0d want %0d", bus.count_o, m_count()); end
            checks++; if (bus.in_ready_o !== m_ready()) begin errors++; $display("FAIL rand_ready: got %b want %b", bus.in_ready_o, m_ready()); end
            checks++; if (bus.almost_full_o !== m_afull()) begin errors++; $display("FAIL rand_afull: got %b want %b", bus.almost_full_o, m_afull()); end
            checks++; if (bus.out_valid_o !== m_valid() || bus.out_data_o !== m_data()) begin errors++; $display("FAIL rand_out: got %b/%h want %b/%h", bus.out_valid_o, bus.out_data_o, m_valid(), m_data()); end
            next_cycle();
            if (m_pushed) sent++;
            pending = bus.in_valid_i && !m_pushed;
            cyc++;
        end
        checks++; if (sent < 1000) begin errors++; $display("FAIL rand_timeout: got %0d beats want 1000", sent); end
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(negedge clk);
            checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== m_data()) begin errors++; $display("FAIL rand_drain: got %b/%h want 1/%h", bus.out_valid_o, bus.out_data_o, m_data()); end
            next_cycle();
            cyc++;
        end
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_drain_timeout: got %0d left want 0", q.size()); end
    endtask

    task automatic test_mid_reset();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid_i = 1'b1;
            bus.in_data_i  = 8'hC0 + 8'(i);
            @(negedge clk);
            next_cycle();
        end
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd3) begin errors++; $display("FAIL midrst_pre_count: got %0d want 3", bus.count_o); end
        bus.in_data_i = 8'h77;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", bus.count_o); end
        checks++; if (bus.out_valid_o !== 1'b0 || bus.out_data_o !== 8'h00) begin errors++; $display("FAIL midrst_out: got %b/%h want 0/00", bus.out_valid_o, bus.out_data_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", bus.in_ready_o); end
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_stale: got %b/%h want 0", bus.out_valid_o, bus.out_data_o); end
            next_cycle();
        end
        bus.in_valid_i = 1'b1;
        bus.in_data_i  = 8'h99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid_o !== m_valid() || bus.out_data_o !== m_data()) begin errors++; $display("FAIL midrst_fresh: got %b/%h want %b/%h", bus.out_valid_o, bus.out_data_o, m_valid(), m_data()); end
            next_cycle();
            bus.in_valid_i = 1'b0;
        end
    endtask

`ifdef ELASTIC_BUFFER_CUT_THROUGH_EN
    task automatic test_cut_through();
        bus.out_ready_i = 1'b1;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'hA5;
        @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'hA5) begin errors++; $display("FAIL cut_same_cycle: got %b/%h want 1/a5", bus.out_valid_o, bus.out_data_o); end
        next_cycle();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd0 || bus.out_valid_o !== 1'b0) begin errors++; $display("FAIL cut_count: got %0d/%b want 0/0", bus.count_o, bus.out_valid_o); end
        next_cycle();
        bus.out_ready_i = 1'b0;
        bus.in_valid_i  = 1'b1;
        bus.in_data_i   = 8'hA6;
        @(negedge clk);
        checks++; if (bus.out_valid_o !== 1'b1 || bus.out_data_o !== 8'hA6) begin errors++; $display("FAIL cut_hold: got %b/%h want 1/a6", bus.out_valid_o, bus.out_data_o); end
        next_cycle();
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.count_o !== 3'd1 || bus.out_data_o !== 8'hA6) begin errors++; $display("FAIL cut_store: got %0d/%h want 1/a6", bus.count_o, bus.out_data_o); end
        next_cycle();
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.in_data_i   = '0;
        bus.out_ready_i = 1'b0;
        test_reset();
        test_fill();
        test_full_pop();
        test_back_to_back();
        test_random();
        test_mid_reset();
`ifdef ELASTIC_BUFFER_CUT_THROUGH_EN
        test_reset();
        test_cut_through();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/elastic_buffer.md
# elastic_buffer

Parametrised elastic buffer: the next generation of the single-entry skid buffer, generalised to DEPTH entries. It sits between two valid/ready pipeline stages. It breaks the ready combinational path: `in_ready_o` is driven only from flops. It absorbs up to DEPTH beats of backpressure and reports occupancy to upstream flow control.

## Interface
- `DATA_WIDTH`, 8: payload width in bits, ≥1.
- `DEPTH`, 4: number of storage entries, ≥2. Does not need to be a power of two.
- `AFULL_THRESH`, 3: `almost_full_o` asserts when occupancy ≥ this value. Legal range 1..DEPTH.
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock; all state updates on its rising edge.
  - `rst`  in  1  synchronous active-high reset, sampled on the rising edge of `clk`.
- `in_valid_i`  in  1  upstream beat valid.
- `in_ready_o`  out  1  buffer can accept a beat. Registered.
- `in_data_i`  in  DATA_WIDTH  upstream payload.
- `out_valid_o`  out  1  downstream beat valid.
- `out_ready_i`  in  1  downstream accepts the beat.
- `out_data_o`  out  DATA_WIDTH  downstream payload.
- `count_o`  out  $clog2(DEPTH+1)  current occupancy. Registered.
- `almost_full_o`  out  1  `count_o` ≥ AFULL_THRESH. Registered.

## Operation
- Storage is a circular array of DEPTH entries with write pointer `wr_ptr`, read pointer `rd_ptr` and occupancy counter `count`.
- Handshakes:
  - push = `in_valid_i & in_ready_o`.
  - pop = `out_valid_o & out_ready_i`.
- Push writes `in_data_i` at `wr_ptr`, then advances `wr_ptr`. Pop advances `rd_ptr`.
- Pointer wrap: a pointer at DEPTH-1 goes to 0 on advance.
- Count update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - unchanged when both or neither occur.
- `in_ready_o` = registered (next_count < DEPTH).
  - It never depends on `out_ready_i` in the same cycle.
  - When full, an incoming beat is refused even if a pop occurs that cycle. Ready rises the cycle after the pop.
- `out_valid_o` = (count ≠ 0).
  - `out_data_o` = entry at `rd_ptr` when valid, otherwise all zeros.
  - Both are flop-driven.
- Ordering: strict FIFO. No beat is dropped or duplicated.
- Upstream must hold `in_data_i` stable while `in_valid_i & ~in_ready_o`. The buffer holds `out_data_o` stable while `out_valid_o & ~out_ready_i`.
- Storage contents are not reset. Only control state is reset.
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0, `count_o`=0, `almost_full_o`=0, pointers=0.
- Reset asserted mid-operation discards all buffered beats at the next rising edge. Reset takes priority over any push or pop in that cycle.

## Timing
- Latency (macro undefined): a beat pushed in cycle N appears on `out_valid_o`/`out_data_o` in cycle N+1 at the earliest.
- Throughput: 1 beat/cycle sustained whenever 0 < count < DEPTH.
- At full (count = DEPTH): `in_ready_o`=0 for at least one cycle. A simultaneous pop brings count to DEPTH−1, and ready is 1 in the next cycle.
- At empty (count = 0): `out_valid_o`=0 unless the cut-through configuration is enabled.
- `count_o` and `almost_full_o` reflect the state after the previous edge, consistent with `in_ready_o`.

## Configuration
- Macro: `ELASTIC_BUFFER_CUT_THROUGH_EN`.
- Defined:
  - When count = 0 and `in_valid_i`=1, `out_valid_o`=1 and `out_data_o`=`in_data_i` combinationally (zero latency).
  - If `out_ready_i`=1 in that cycle, the beat passes through with no write and count stays 0.
  - If `out_ready_i`=0, the beat is written normally and count becomes 1.
  - `in_ready_o` remains registered.
- Undefined: no combinational in→out path. All outputs are flop-driven, with minimum latency 1.

## Test plan
- Reset check (DATA_WIDTH=8, DEPTH=4): hold `rst` for 2 cycles, then release -> `in_ready_o`=1, `out_valid_o`=0, `out_data_o`=0x00, `count_o`=0, `almost_full_o`=0.
- Fill with `out_ready_i`=0: push 0x11, 0x22, 0x33, 0x44 on consecutive cycles ->
  - `count_o` goes 1,2,3,4.
  - `almost_full_o`=1 from count 3.
  - `in_ready_o`=0 after the 4th push.
  - A 5th beat 0x55 is held and not accepted.
- Full with simultaneous pop: from full, raise `out_ready_i` for 1 cycle with 0x55 pending ->
  - 0x11 pops and count becomes 3.
  - 0x55 is accepted the next cycle.
  - Drain order is 0x22, 0x33, 0x44, 0x55.
- Wrap-around streaming: `out_ready_i`=1 throughout, push 0x00..0x09 back to back -> output is 0x00..0x09 in order, with 1-cycle latency, 1 beat/cycle, and count ≤ 1.
- Random backpressure: 1000 beats with random `in_valid_i` and `out_ready_i` at 50% each -> output sequence equals input sequence, and `count_o` always equals pushes minus pops.
- Mid-operation reset with count=3: assert `rst` for 1 cycle together with a push -> next cycle count=0 and `out_valid_o`=0, and no stale beat ever appears. With `ELASTIC_BUFFER_CUT_THROUGH_EN` defined, also: with count=0, push 0xA5 with `out_ready_i`=1 -> 0xA5 appears on `out_data_o` in the same cycle, and count stays 0.
